// File: rtl/alu_accum_seq.sv
// Accumulator ALU with valid/ready capture and a shift-add multiplier.
// Optional macro ALU_SATURATE_EN: clamp overflowing results, never enter ERROR.
module alu_accum_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       acc_sel,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             ovf,
    output logic             error,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_ERROR = 2'b11
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic               r_ovf;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_a_sel;
    logic               w_accept;
    logic               w_done;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_store;
    logic               w_err_go;
    logic               w_clr;

    assign w_accept = (r_state == S_READY) & on & in_valid;
    assign w_done   = (r_state == S_RUN) &
                      ((r_op != OP_MUL) | (r_cnt == LAST));

    // A operand source chosen at acceptance
    always_comb begin
        w_a_sel = r_acc;
        unique case (acc_sel)
            2'b01:   w_a_sel = a_in;
            2'b10:   w_a_sel = '0;
            default: w_a_sel = r_acc;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit (LSB of the right-shifting B copy) is set
    assign w_prod_nxt = r_prod + (r_b[0] ? r_mcand : '0);
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff     = {1'b0, r_a} - {1'b0, r_b};

    // Raw wrapped result and overflow flag of the op in flight
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        unique case (r_op)
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_NOT:  w_res = ~r_a;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_ovf = w_diff[WIDTH];
            end
            OP_MUL: begin
                w_res = w_prod_nxt[WIDTH-1:0];
                w_ovf = |w_prod_nxt[2*WIDTH-1:WIDTH];
            end
            OP_PASS: w_res = r_b;
            default: w_res = '0;
        endcase
    end

`ifdef ALU_SATURATE_EN
    assign w_store  = !w_ovf ? w_res :
                      (r_op == OP_SUB) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    assign w_err_go = 1'b0;
    assign w_clr    = 1'b0;
`else
    assign w_store  = w_res;
    assign w_err_go = w_ovf;
    assign w_clr    = err_clr;
`endif

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_READY;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; on=0 in READY wins over a pending request
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_OFF: begin
                if (on) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (!on)          w_state_nxt = S_OFF;
                else if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_done) begin
                    if (w_err_go) w_state_nxt = S_ERROR;
                    else if (!on) w_state_nxt = S_OFF;
                    else          w_state_nxt = S_READY;
                end
            end
            S_ERROR: begin
                if (w_clr)    w_state_nxt = S_READY;
                else if (!on) w_state_nxt = S_OFF;
            end
            default: w_state_nxt = S_READY;
        endcase
    end

    // Operand capture, multiplier iteration and result/flag update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= w_done;
            if (w_accept) begin
                r_a     <= w_a_sel;
                r_b     <= b_in;
                r_op    <= op;
                r_mcand <= {{WIDTH{1'b0}}, w_a_sel};
                r_prod  <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_RUN && r_op == OP_MUL) begin
                r_prod  <= w_prod_nxt;
                r_mcand <= r_mcand << 1;
                r_b     <= r_b >> 1;
                r_cnt   <= w_done ? '0 : r_cnt + CW'(1);
            end
            if (w_done) begin
                r_acc <= w_store;
                r_ovf <= w_ovf;
            end else if (r_state == S_ERROR && w_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == S_READY) & on;
    assign state     = r_state;
    assign error     = (r_state == S_ERROR);
    assign result    = r_acc;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;

endmodule
